// File: rtl/alu16.sv
// 16-bit registered integer ALU for the MISC-V datapath: eight operations,
// result and NZCV-style status flags registered with one-cycle latency.
module alu16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] FirstInput,
  input  logic [WIDTH-1:0] SecondInput,
  input  logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] OutputData,
  output logic             IsZero,
  output logic             IsNegative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_OR  = 3'd3,
    OP_AND = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  alu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_ovf;
  logic             sub_ovf;

  logic             sh_neg;
  logic [WIDTH-1:0] sh_mag;
  logic             sh_big;
  logic [SW-1:0]    sh_amt;
  logic [WIDTH-1:0] sh_left;
  logic [WIDTH-1:0] sh_right;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d,   zero_q;
  logic             neg_d,    neg_q;
  logic             carry_d,  carry_q;
  logic             ovf_d,    ovf_q;

  assign op = alu_op_e'(ALUOp);
  assign a  = FirstInput;
  assign b  = SecondInput;

  // Subtraction as A + ~B + 1 so the carry-out is directly the NOT-borrow.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
    sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
  end

  // Magnitude of the signed shift amount; the most negative value negates to
  // itself, which read unsigned is still >= WIDTH and so saturates correctly.
  always_comb begin
    sh_neg   = b[WIDTH-1];
    sh_mag   = sh_neg ? (~b + WIDTH'(1)) : b;
    sh_big   = (32'(sh_mag) >= WIDTH);
    sh_amt   = sh_mag[SW-1:0];
    sh_left  = sh_big ? '0 : (a << sh_amt);
    sh_right = sh_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> sh_amt);
  end

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    case (op)
      OP_NOP: result_d = '0;
      OP_ADD: begin
        result_d = add_full[WIDTH-1:0];
        carry_d  = add_full[WIDTH];
        ovf_d    = add_ovf;
      end
      OP_SUB: begin
        result_d = sub_full[WIDTH-1:0];
        carry_d  = sub_full[WIDTH];
        ovf_d    = sub_ovf;
      end
      OP_OR:  result_d = a | b;
      OP_AND: result_d = a & b;
      OP_XOR: result_d = a ^ b;
      OP_SHL: result_d = sh_neg ? sh_right : sh_left;
      OP_SHR: result_d = sh_neg ? sh_left : sh_right;
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
    neg_d  = result_d[WIDTH-1];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign OutputData = result_q;
  assign IsZero     = zero_q;
  assign IsNegative = neg_q;
  assign Carry      = carry_q;
  assign Overflow   = ovf_q;

endmodule

// File: tb/tb_alu16.sv
// Directed, table-driven bench for alu16: hand-computed result/flag vectors
// plus reset, NOP and mid-cycle input-change sequences.
module tb_alu16;

  logic        CLK;
  logic        RST_N;
  logic [15:0] FirstInput;
  logic [15:0] SecondInput;
  logic [2:0]  ALUOp;
  logic [15:0] OutputData;
  logic        IsZero;
  logic        IsNegative;
  logic        Carry;
  logic        Overflow;

  int checks;
  int failures;

  alu16 #(.WIDTH(16)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .FirstInput (FirstInput),
    .SecondInput(SecondInput),
    .ALUOp      (ALUOp),
    .OutputData (OutputData),
    .IsZero     (IsZero),
    .IsNegative (IsNegative),
    .Carry      (Carry),
    .Overflow   (Overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic z, input logic n,
                         input logic c, input logic v);
    vec_t t;
    t.name = name; t.op = op; t.a = a; t.b = b;
    t.res = res; t.z = z; t.n = n; t.c = c; t.v = v;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [15:0] res, input logic z,
                       input logic n, input logic c, input logic v);
    checks++;
    if ({OutputData, IsZero, IsNegative, Carry, Overflow} !== {res, z, n, c, v}) begin
      failures++;
      $display("FAIL %s: actual res=%h z=%b n=%b c=%b v=%b required res=%h z=%b n=%b c=%b v=%b",
               name, OutputData, IsZero, IsNegative, Carry, Overflow, res, z, n, c, v);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge CLK);
    ALUOp = op; FirstInput = a; SecondInput = b;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RST_N = 1'b1;
    ALUOp = 3'd1; FirstInput = 16'd5; SecondInput = 16'd7;

    // ADD
    add_vec("add_1_1",      3'd1, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 0);
    add_vec("add_15_28",    3'd1, 16'h000F, 16'h001C, 16'h002B, 0, 0, 0, 0);
    add_vec("add_m13_4",    3'd1, 16'hFFF3, 16'h0004, 16'hFFF7, 0, 1, 0, 0);
    add_vec("add_m3_m5",    3'd1, 16'hFFFD, 16'hFFFB, 16'hFFF8, 0, 1, 1, 0);
    add_vec("add_ovf",      3'd1, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1);
    add_vec("add_wrap0",    3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0);
    add_vec("add_negovf",   3'd1, 16'h8000, 16'h8000, 16'h0000, 1, 0, 1, 1);
    // SUB
    add_vec("sub_1_1",      3'd2, 16'h0001, 16'h0001, 16'h0000, 1, 0, 1, 0);
    add_vec("sub_15_28",    3'd2, 16'h000F, 16'h001C, 16'hFFF3, 0, 1, 0, 0);
    add_vec("sub_m13_4",    3'd2, 16'hFFF3, 16'h0004, 16'hFFEF, 0, 1, 1, 0);
    add_vec("sub_13_m4",    3'd2, 16'h000D, 16'hFFFC, 16'h0011, 0, 0, 0, 0);
    add_vec("sub_m3_m5",    3'd2, 16'hFFFD, 16'hFFFB, 16'h0002, 0, 0, 1, 0);
    add_vec("sub_ovf",      3'd2, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1, 1);
    // Logic ops: carry/overflow stay 0 even with large operands
    add_vec("or_1_2",       3'd3, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0);
    add_vec("or_m15_4",     3'd3, 16'hFFF1, 16'h0004, 16'hFFF5, 0, 1, 0, 0);
    add_vec("or_0_0",       3'd3, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0);
    add_vec("and_1_2",      3'd4, 16'h0001, 16'h0002, 16'h0000, 1, 0, 0, 0);
    add_vec("and_m15_4",    3'd4, 16'hFFF1, 16'h0004, 16'h0000, 1, 0, 0, 0);
    add_vec("and_m15_3",    3'd4, 16'hFFF1, 16'h0003, 16'h0001, 0, 0, 0, 0);
    add_vec("xor_ff_f0f",   3'd5, 16'h00FF, 16'h0F0F, 16'h0FF0, 0, 0, 0, 0);
    add_vec("xor_big",      3'd5, 16'hFFFF, 16'h7FFF, 16'h8000, 0, 1, 0, 0);
    // SHL
    add_vec("shl_1_1",      3'd6, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 0);
    add_vec("shl_10_1",     3'd6, 16'h000A, 16'h0001, 16'h0014, 0, 0, 0, 0);
    add_vec("shl_m4_3",     3'd6, 16'hFFFC, 16'h0003, 16'hFFE0, 0, 1, 0, 0);
    add_vec("shl_8_m3",     3'd6, 16'h0008, 16'hFFFD, 16'h0001, 0, 0, 0, 0);
    add_vec("shl_1_16",     3'd6, 16'h0001, 16'h0010, 16'h0000, 1, 0, 0, 0);
    add_vec("shl_0_x",      3'd6, 16'h0000, 16'h1234, 16'h0000, 1, 0, 0, 0);
    add_vec("shl_by0",      3'd6, 16'hABCD, 16'h0000, 16'hABCD, 0, 1, 0, 0);
    add_vec("shl_15",       3'd6, 16'h8001, 16'h000F, 16'h8000, 0, 1, 0, 0);
    add_vec("shl_m15",      3'd6, 16'h8000, 16'hFFF1, 16'hFFFF, 0, 1, 0, 0);
    add_vec("shl_min",      3'd6, 16'h8000, 16'h8000, 16'hFFFF, 0, 1, 0, 0);
    add_vec("shl_m16_pos",  3'd6, 16'h4000, 16'hFFF0, 16'h0000, 1, 0, 0, 0);
    add_vec("shl_256",      3'd6, 16'h0001, 16'h0100, 16'h0000, 1, 0, 0, 0);
    // SHR
    add_vec("shr_2_1",      3'd7, 16'h0002, 16'h0001, 16'h0001, 0, 0, 0, 0);
    add_vec("shr_10_1",     3'd7, 16'h000A, 16'h0001, 16'h0005, 0, 0, 0, 0);
    add_vec("shr_m8_3",     3'd7, 16'hFFF8, 16'h0003, 16'hFFFF, 0, 1, 0, 0);
    add_vec("shr_8_m3",     3'd7, 16'h0008, 16'hFFFD, 16'h0040, 0, 0, 0, 0);
    add_vec("shr_m1_20",    3'd7, 16'hFFFF, 16'h0014, 16'hFFFF, 0, 1, 0, 0);
    add_vec("shr_0_x",      3'd7, 16'h0000, 16'hBEEF, 16'h0000, 1, 0, 0, 0);
    add_vec("shr_15",       3'd7, 16'h8000, 16'h000F, 16'hFFFF, 0, 1, 0, 0);
    add_vec("shr_16_pos",   3'd7, 16'h4000, 16'h0010, 16'h0000, 1, 0, 0, 0);
    add_vec("shr_min",      3'd7, 16'h7FFF, 16'h8000, 16'h0000, 1, 0, 0, 0);
    add_vec("shr_m15",      3'd7, 16'h0001, 16'hFFF1, 16'h8000, 0, 1, 0, 0);
    add_vec("shr_by0",      3'd7, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0, 0);
    add_vec("shr_4_pos",    3'd7, 16'h1234, 16'h0004, 16'h0123, 0, 0, 0, 0);

    // Asynchronous reset from power-up
    #2 RST_N = 1'b0;
    #1 check("reset_async", 16'h0000, 1, 0, 0, 0);
    @(posedge CLK); #1;
    check("reset_held", 16'h0000, 1, 0, 0, 0);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    check("post_reset_add", 16'h000C, 0, 0, 0, 0);

    // Table: one operation issued every cycle
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v);
    end

    // NOP ignores operands
    for (int i = 0; i < 5; i++) begin
      issue(3'd0, 16'($urandom), 16'($urandom));
      check("nop_rand", 16'h0000, 1, 0, 0, 0);
    end

    // Input changes mid-cycle are not visible until the next edge
    issue(3'd1, 16'h7FFF, 16'h0001);
    check("hold_pre", 16'h8000, 0, 1, 0, 1);
    @(negedge CLK);
    ALUOp = 3'd5; FirstInput = 16'h00F0; SecondInput = 16'h000F;
    #2 check("hold_mid", 16'h8000, 0, 1, 0, 1);
    @(posedge CLK); #1;
    check("hold_post", 16'h00FF, 0, 0, 0, 0);

    // Reset asserted mid-cycle with an ADD in flight
    issue(3'd1, 16'hFFFD, 16'hFFFB);
    check("rst_pre", 16'hFFF8, 0, 1, 1, 0);
    @(negedge CLK);
    ALUOp = 3'd1; FirstInput = 16'd5; SecondInput = 16'd7;
    RST_N = 1'b0;
    #1 check("rst_midcycle", 16'h0000, 1, 0, 0, 0);
    @(posedge CLK); #1;
    check("rst_over_edge", 16'h0000, 1, 0, 0, 0);
    @(negedge CLK) RST_N = 1'b1;
    #1 check("rst_release", 16'h0000, 1, 0, 0, 0);
    @(posedge CLK); #1;
    check("rst_then_add", 16'h000C, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu16.md
Name: alu16

Overview:
- 16-bit registered integer ALU in the MISC-V datapath. It sits between the register-file/immediate operand muxes and the write-back path.
- Computes one of eight operations selected by a 3-bit opcode on two's-complement 16-bit operands.
- Result and status flags are registered on the rising clock edge, so latency is one cycle.

Parameters:
- WIDTH, 16, operand/result width (all behaviour below is stated for 16).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- FirstInput  input  16  operand A, two's complement.
- SecondInput  input  16  operand B, two's complement; for shifts, the signed shift amount.
- ALUOp  input  3  operation select.
- OutputData  output  16  registered result.
- IsZero  output  1  registered; 1 when OutputData is 0.
- IsNegative  output  1  registered; equals OutputData[15].
- Carry  output  1  registered; carry-out for ADD, NOT-borrow for SUB, 0 for all other ops.
- Overflow  output  1  registered; signed overflow for ADD/SUB, 0 for all other ops.

Behaviour:
- Reset: while RST_N=0 (asynchronous assert, synchronous-safe deassert):
  - OutputData=0, IsZero=1, IsNegative=0, Carry=0, Overflow=0.
  - Reset overrides any operation in flight.
- Each rising CLK edge with RST_N=1 registers f(FirstInput, SecondInput, ALUOp) and its flags. Combinational input changes are not visible until the next edge.
- Opcodes:
  - 0 NOP: result 0, independent of operands.
  - 1 ADD: A+B mod 2^16.
    - Carry = bit 16 of the unsigned sum.
    - Overflow = A,B same sign and result sign differs.
  - 2 SUB: A−B mod 2^16.
    - Carry = 1 when no borrow (A ≥ B unsigned).
    - Overflow = A,B differ in sign and result sign differs from A.
  - 3 OR: bitwise A|B.
  - 4 AND: bitwise A&B.
  - 5 XOR: bitwise A^B.
  - 6 SHL: shift A left by signed amount B.
    - B ≥ 0: logical left by B; zero fill; B ≥ 16 gives 0.
    - B < 0: arithmetic right shift by −B; sign fill; −B ≥ 16 gives all sign bits.
  - 7 SHR: arithmetic right shift of A by signed amount B.
    - B ≥ 0: sign fill; B ≥ 16 gives 0x0000 or 0xFFFF per the sign of A.
    - B < 0: logical left shift by −B; −B ≥ 16 gives 0.
    - B = −32768 is treated as magnitude ≥ 16.
- Shift amount is the full 16-bit signed value of B, not truncated to 4 bits.
- Shift by 0 returns A unchanged.
- Flags:
  - IsZero and IsNegative are derived from the registered result for every opcode, NOP included (NOP gives IsZero=1).
  - Carry and Overflow are forced to 0 for opcodes other than 1 and 2.
- No handshake: a new operation may be issued every cycle, with full throughput.
- Unknown/X opcodes are not possible; all 8 codes are defined.

Test Plan:
- Reset: RST_N=0 mid-cycle with ALUOp=1, A=5, B=7 → outputs immediately 0, IsZero=1. Release RST_N, then one edge later OutputData=12.
- NOP: ALUOp=0 with 5 random A/B pairs → OutputData=0, IsZero=1 every cycle.
- ADD/SUB after one edge each:
  - 1+1=2 (IsZero=0); 15+28=43; −13+4=−9; −3+−5=−8 (Carry=1).
  - 0x7FFF+1=0x8000 (Overflow=1).
  - SUB: 1−1=0 (IsZero=1); 15−28=−13; −13−4=−17; 13−(−4)=17; −3−(−5)=2.
- Logic:
  - OR: 1|2=3; −15|4=−11; 0|0=0 (IsZero=1).
  - AND: 1&2=0; −15&4=0; −15&3=1.
  - XOR: 0x00FF^0x0F0F=0x0FF0.
- SHL: 1<<1=2; 10<<1=20; −4<<3=−32; 8 with B=−3 → 1; 1 with B=16 → 0; A=0 with random B → 0 (IsZero=1).
- SHR: 2>>1=1; 10>>1=5; −8>>3=−1; 8 with B=−3 → 64; −1 with B=20 → −1; A=0 with random B → 0 (IsZero=1).
